// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions. Both the fetch and decode stages use these
// types and constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0063;  // beq x0,x0,0

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage : riscv_pkg

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register. Priority is reset > flush > load > hold. Reset and
// flush both leave a bubble: pc 0, NOP word, valid 0.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           instr_i,
  output riscv_pkg::if_id_t     if_id_o
);
  import riscv_pkg::*;

  if_id_t if_id_q;
  if_id_t if_id_d;
  if_id_t bubble;

  always_comb begin
    bubble.pc    = '0;
    bubble.instr = NOP_WORD;
    bubble.valid = 1'b0;
  end

  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d = bubble;
    end else if (load_i) begin
      if_id_d.pc    = pc_i;
      if_id_d.instr = instr_i;
      if_id_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q <= bubble;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule : if_id_reg

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the architectural PC, drives the zero-latency instruction
// memory, captures into IF/ID, and stops on the self-branch halt word.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter bit          HALT_DETECT = 1'b1,
  parameter logic [31:0] HALT_INSTR  = 32'h0000_0063,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_count_o
);
  import riscv_pkg::*;

  // Handshake: stall_i holds PC, IF/ID and counter; flush_i overrides stall_i and
  // always bubbles IF/ID; both are sampled on the rising edge of clk.

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_load;
  logic             ifid_flush;
  logic [31:0]      redirect_aligned;
  logic             is_halt_word;
  if_id_t           if_id;

  assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};
  assign is_halt_word     = HALT_DETECT && (imem_instr_i == HALT_INSTR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        ifid_flush = flush_i;
        if (flush_i) pc_d = redirect_aligned;
      end
      RUN: begin
        if (flush_i) begin
          pc_d       = redirect_aligned;
          ifid_flush = 1'b1;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          // The halt word is kept in IF/ID but the PC parks on its address.
          if (is_halt_word) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HALT: begin
        // Any non-stalled or flushed cycle drains IF/ID to a bubble; PC is frozen.
        ifid_flush = flush_i || !stall_i;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load_i   (ifid_load),
    .flush_i  (ifid_flush),
    .pc_i     (pc_q),
    .instr_i  (imem_instr_i),
    .if_id_o  (if_id)
  );

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_valid_o = if_id.valid;
  assign halted_o      = HALT_DETECT && (state_q == HALT);
  assign fetch_count_o = cnt_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: boot, stall, flush, halt, reset-in-halt,
// PC wrap and counter saturation against hand-computed values.
module tb_instruction_fetch;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      redirect_pc_i;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_instr_i;
  logic [31:0]      if_id_pc_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic             halted_o;
  logic [CNT_W-1:0] fetch_count_o;

  int n_checks;
  int n_fail;

  instruction_fetch #(
    .RESET_PC    (32'h0000_0000),
    .NOP_INSTR   (32'h0000_0013),
    .HALT_DETECT (1'b1),
    .HALT_INSTR  (32'h0000_0063),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o),
    .fetch_count_o (fetch_count_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h00C0_0413;
      32'h0000_0004: rom = 32'h0090_0493;
      32'h0000_0020: rom = 32'h0000_0063;
      default:       rom = 32'h0000_0013;
    endcase
  endfunction

  always_comb imem_instr_i = rom(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".pc"},    if_id_pc_o,    pc);
    check({tag, ".instr"}, if_id_instr_o, instr);
    check({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, valid});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".addr"},   imem_addr_o, 32'h0);
    check_ifid(tag, 32'h0, 32'h0000_0013, 1'b0);
    check({tag, ".halted"}, {31'd0, halted_o}, 32'd0);
    check({tag, ".count"},  {{(32-CNT_W){1'b0}}, fetch_count_o}, 32'd0);
  endtask

  task automatic check_count(input string tag, input int exp);
    check(tag, {{(32-CNT_W){1'b0}}, fetch_count_o}, exp[31:0]);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = 32'h0;

    // Reset, boot and two plain captures
    tick();
    check_reset_values("rst0");
    reset = 1'b0;
    tick();
    check("boot.valid", {31'd0, if_id_valid_o}, 32'd0);
    check("boot.addr", imem_addr_o, 32'h0);
    tick();
    check_ifid("cap0", 32'h0, 32'h00C0_0413, 1'b1);
    tick();
    check_ifid("cap1", 32'h4, 32'h0090_0493, 1'b1);
    check_count("cap1.count", 2);
    check("cap1.addr", imem_addr_o, 32'h8);

    // Stall for three cycles after the first capture
    reset = 1'b1;
    tick();
    check_reset_values("rst1");
    reset = 1'b0;
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.addr", imem_addr_o, 32'h4);
      check_ifid("stall", 32'h0, 32'h00C0_0413, 1'b1);
      check_count("stall.count", 1);
    end
    stall_i = 1'b0;
    tick();
    check_ifid("unstall", 32'h4, 32'h0090_0493, 1'b1);
    check_count("unstall.count", 2);

    // Flush wins over stall; redirect target is word-aligned
    stall_i       = 1'b1;
    flush_i       = 1'b1;
    redirect_pc_i = 32'h0000_0022;
    tick();
    check("flush.addr", imem_addr_o, 32'h20);
    check("flush.valid", {31'd0, if_id_valid_o}, 32'd0);
    check("flush.instr", if_id_instr_o, 32'h0000_0013);
    check_count("flush.count", 2);
    stall_i = 1'b0;
    flush_i = 1'b0;

    // Halt word at 0x20
    tick();
    check_ifid("haltcap", 32'h20, 32'h0000_0063, 1'b1);
    check("haltcap.addr", imem_addr_o, 32'h20);
    check("haltcap.halted", {31'd0, halted_o}, 32'd1);
    check_count("haltcap.count", 3);
    tick();
    check("halt.valid", {31'd0, if_id_valid_o}, 32'd0);
    check("halt.instr", if_id_instr_o, 32'h0000_0013);
    check("halt.addr", imem_addr_o, 32'h20);
    check_count("halt.count", 3);
    flush_i       = 1'b1;
    redirect_pc_i = 32'h0;
    tick();
    check("haltflush.addr", imem_addr_o, 32'h20);
    check("haltflush.halted", {31'd0, halted_o}, 32'd1);
    flush_i = 1'b0;

    // Reset while halted and stalled
    stall_i = 1'b1;
    reset   = 1'b1;
    tick();
    check_reset_values("rsthalt");
    reset   = 1'b0;
    stall_i = 1'b0;
    tick();
    check("rsthalt.boot.valid", {31'd0, if_id_valid_o}, 32'd0);
    tick();
    check_ifid("rsthalt.cap", 32'h0, 32'h00C0_0413, 1'b1);
    check_count("rsthalt.count", 1);

    // PC wrap from FFFF_FFFC to 0
    flush_i       = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    check("wrap.pre", imem_addr_o, 32'hFFFF_FFFC);
    flush_i = 1'b0;
    tick();
    check_ifid("wrap.cap", 32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    check("wrap.addr", imem_addr_o, 32'h0);
    check_count("wrap.count", 2);

    // Counter saturation (CNT_W=4 saturates at 15), away from the halt word
    flush_i       = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    check_count("sat.reach", 15);
    for (int i = 0; i < 3; i++) tick();
    check_count("sat.hold", 15);
    check("sat.addr", imem_addr_o, 32'h0000_0140);
    check("sat.halted", {31'd0, halted_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch
